// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data-memory path.
// Used by dmem_arbiter and by the mem stage that it drives.
//   sec_t            access size encoding (byte / half / word)
//   MEM_READ/WRITE   memRW encoding seen by the memory
//   is_misaligned    size/address alignment check
//   access_error     full legality check (size, alignment, range)
package dmem_pkg;

  typedef enum logic [1:0] {
    SEC_BYTE = 2'b00,
    SEC_HALF = 2'b01,
    SEC_WORD = 2'b10
  } sec_t;

  // The one encoding of the 2-bit size field that sec_t leaves out.
  localparam logic [1:0] SEC_ILLEGAL = 2'b11;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] sec, input logic [31:0] addr);
    logic mis;
    mis = 1'b0;
    case (sec)
      SEC_HALF: mis = addr[0];
      SEC_WORD: mis = (addr[1:0] != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Any address bit at or above addr_w means the byte is outside the memory.
  function automatic logic is_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return ((addr >> addr_w) != 32'd0);
  endfunction

  function automatic logic access_error(input logic [1:0] sec, input logic [31:0] addr,
                                        input int unsigned addr_w);
    return (sec == SEC_ILLEGAL) || is_misaligned(sec, addr) || is_out_of_range(addr, addr_w);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter with a burst lock for port 1.
//   clk, rst  clock and asynchronous active-high reset
//   req       per-port request
//   lock      port 1 asks to keep ownership once it holds it
//   gnt       one-hot grant, combinational, zero while rst is high
//   last_gnt  index of the most recently granted port (reset 1)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt,
  output logic       last_gnt
);

  logic last_gnt_reg;
  logic last_gnt_next;
  logic lock_active;

  // Lock only binds once port 1 actually owns the memory; if port 0 was
  // last, a tie still goes to port 1 and the lock engages from then on.
  assign lock_active = lock & last_gnt_reg;

  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (lock_active) begin
      gnt = {req[1], 1'b0};
    end else if (req == 2'b11) begin
      gnt = last_gnt_reg ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Grants are only issued to requesting ports, so any grant is a transfer.
  always_comb begin
    last_gnt_next = last_gnt_reg;
    if (gnt[1]) begin
      last_gnt_next = 1'b1;
    end else if (gnt[0]) begin
      last_gnt_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_reg <= 1'b1;
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end

  assign last_gnt = last_gnt_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core LSU
// (port 0) and the debug/loader (port 1).
//   clk, rst               clock, asynchronous active-high reset
//   req_i, we_i            per-port request (held until granted) and store flag
//   sec0_i/sec1_i          access size per port (00 byte, 01 half, 10 word)
//   addr0_i/addr1_i        byte address per port
//   wdata0_i/wdata1_i      store data per port
//   dbg_lock_i             debug burst lock
//   gnt_o                  one-hot combinational grant
//   rvalid_o, rdata_o, err_o  response, one cycle after a read or error access
//   mem_rw_o, mem_sec_o, mem_addr_o, mem_wdata_o  drive to the memory
//   mem_rdata_i            memory read data, one cycle after the address
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        sec0_i,
  input  logic [1:0]        sec1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              dbg_lock_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_rw_o,
  output logic [1:0]        mem_sec_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic [1:0]        sec_arr   [2];
  logic [31:0]       addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [1:0]        port_err;

  logic [1:0] gnt;
  logic       last_gnt;
  logic       sel;
  logic       xfer;
  logic       acc_err;
  logic       legal;

  logic resp_valid_reg, resp_valid_next;
  logic resp_owner_reg, resp_owner_next;
  logic resp_err_reg,   resp_err_next;

  assign sec_arr[0]   = sec0_i;
  assign sec_arr[1]   = sec1_i;
  assign addr_arr[0]  = addr0_i;
  assign addr_arr[1]  = addr1_i;
  assign wdata_arr[0] = wdata0_i;
  assign wdata_arr[1] = wdata1_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port_check
      assign port_err[gi] = access_error(sec_arr[gi], addr_arr[gi], ADDR_W);
    end
  endgenerate

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_i),
    .lock     (dbg_lock_i),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  assign gnt_o   = gnt;
  assign sel     = gnt[1];
  assign xfer    = |gnt;
  assign acc_err = port_err[sel];
  assign legal   = xfer & ~acc_err;

  // Idle and error cycles park the memory on a harmless word read at 0 so
  // a rejected store can never reach it.
  always_comb begin
    mem_rw_o    = MEM_READ;
    mem_sec_o   = SEC_WORD;
    mem_addr_o  = 32'd0;
    mem_wdata_o = '0;
    if (legal) begin
      mem_rw_o    = we_i[sel] ? MEM_WRITE : MEM_READ;
      mem_sec_o   = sec_arr[sel];
      mem_addr_o  = addr_arr[sel];
      mem_wdata_o = wdata_arr[sel];
    end
  end

  // Legal stores are fire-and-forget; reads and every error get a response.
  always_comb begin
    resp_valid_next = xfer & (acc_err | ~we_i[sel]);
    resp_owner_next = sel;
    resp_err_next   = acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_owner_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= resp_valid_next;
      resp_owner_reg <= resp_owner_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  assign rvalid_o = {resp_valid_reg & resp_owner_reg, resp_valid_reg & ~resp_owner_reg};
  assign err_o    = resp_valid_reg & resp_err_reg;
  // The memory answers the cycle after the address, which lines up with the
  // response register; error responses force zero data.
  assign rdata_o  = (resp_valid_reg & ~resp_err_reg) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_i = 2'b00;
  logic [1:0]        we_i = 2'b00;
  logic [1:0]        sec0_i = 2'b10;
  logic [1:0]        sec1_i = 2'b10;
  logic [31:0]       addr0_i = 32'd0;
  logic [31:0]       addr1_i = 32'd0;
  logic [DATA_W-1:0] wdata0_i = '0;
  logic [DATA_W-1:0] wdata1_i = '0;
  logic              dbg_lock_i = 1'b0;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;
  logic              mem_rw_o;
  logic [1:0]        mem_sec_o;
  logic [31:0]       mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
    .sec0_i(sec0_i), .sec1_i(sec1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .dbg_lock_i(dbg_lock_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_rw_o(mem_rw_o), .mem_sec_o(mem_sec_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Byte-wide stand-in for the mem stage: acts on whatever the DUT drives.
  logic [7:0]  stub_b [0:2047] = '{default: 8'h00};
  wire  [10:0] st_a = mem_addr_o[10:0];
  wire  [10:0] st_w = {mem_addr_o[10:2], 2'b00};

  always @(posedge clk) begin
    if (mem_rw_o == 1'b0) begin
      case (mem_sec_o)
        2'b00: stub_b[st_a] <= mem_wdata_o[7:0];
        2'b01: begin
          stub_b[st_a]         <= mem_wdata_o[7:0];
          stub_b[st_a + 11'd1] <= mem_wdata_o[15:8];
        end
        2'b10: begin
          stub_b[st_w]         <= mem_wdata_o[7:0];
          stub_b[st_w + 11'd1] <= mem_wdata_o[15:8];
          stub_b[st_w + 11'd2] <= mem_wdata_o[23:16];
          stub_b[st_w + 11'd3] <= mem_wdata_o[31:24];
        end
        default: ;
      endcase
    end
    mem_rdata_i <= {stub_b[st_w + 11'd3], stub_b[st_w + 11'd2], stub_b[st_w + 11'd1], stub_b[st_w]};
  end

  // Reference model: word-organised memory image plus expected arbiter state.
  logic [31:0] ref_w [0:511] = '{default: 32'h0};
  int          last_m = 1;
  bit          pend_v = 1'b0;
  int          pend_own = 0;
  bit          pend_err = 1'b0;
  logic [31:0] pend_data = 32'h0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [1:0]  obs_gnt;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] wq,
                      input logic [1:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk);
    logic [1:0]  eg;
    int          k;
    bit          e;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    int          lane;
    @(negedge clk);
    req_i = rq; we_i = wq; dbg_lock_i = lk;
    sec0_i = s0; addr0_i = a0; wdata0_i = d0;
    sec1_i = s1; addr1_i = a1; wdata1_i = d1;
    #1;
    if (lk && last_m == 1)      eg = rq[1] ? 2'b10 : 2'b00;
    else if (rq == 2'b11)       eg = (last_m == 1) ? 2'b01 : 2'b10;
    else                        eg = rq;
    k = (eg == 2'b10) ? 1 : 0;
    s = (k == 1) ? s1 : s0;
    a = (k == 1) ? a1 : a0;
    d = (k == 1) ? d1 : d0;
    e = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
        || (a >= (32'd1 << ADDR_W));

    chk("gnt", {30'd0, gnt_o}, {30'd0, eg});
    chk("rvalid", {30'd0, rvalid_o}, pend_v ? ((pend_own == 1) ? 32'd2 : 32'd1) : 32'd0);
    chk("err", {31'd0, err_o}, {31'd0, pend_v && pend_err});
    chk("rdata", rdata_o, (pend_v && !pend_err) ? pend_data : 32'd0);
    if (eg != 2'b00 && !e) begin
      chk("mem_rw", {31'd0, mem_rw_o}, {31'd0, !wq[k]});
      chk("mem_sec", {30'd0, mem_sec_o}, {30'd0, s});
      chk("mem_addr", mem_addr_o, a);
      chk("mem_wdata", mem_wdata_o, d);
    end else begin
      chk("idle_rw", {31'd0, mem_rw_o}, 32'd1);
      chk("idle_sec", {30'd0, mem_sec_o}, 32'd2);
      chk("idle_addr", mem_addr_o, 32'd0);
      chk("idle_wdata", mem_wdata_o, 32'd0);
    end
    obs_gnt = gnt_o;
    obs_rdata = rdata_o;
    $display("cyc %0d req=%b we=%b lock=%b gnt=%b rvalid=%b err=%b rdata=%h mem_rw=%b mem_addr=%h",
             cyc, rq, wq, lk, gnt_o, rvalid_o, err_o, rdata_o, mem_rw_o, mem_addr_o);

    pend_v    = (eg != 2'b00) && (e || !wq[k]);
    pend_own  = k;
    pend_err  = e;
    pend_data = ref_w[a[10:2]];
    if (eg != 2'b00 && !e && wq[k]) begin
      lane = int'(a[1:0]);
      case (s)
        2'b00: ref_w[a[10:2]][lane*8 +: 8] = d[7:0];
        2'b01: ref_w[a[10:2]][lane*8 +: 16] = d[15:0];
        default: ref_w[a[10:2]] = d;
      endcase
    end
    if (eg != 2'b00) last_m = k;
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b10, 32'd0, 32'd0, 2'b10, 32'd0, 32'd0, 1'b0);
  endtask

  // Random-phase per-port pending transactions.
  bit          act [2];
  logic        r_we [2];
  logic [1:0]  r_sec [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd [2];
  logic        r_lock;

  initial begin
    // Reset state, with both requests asserted to show the grant is held off.
    @(negedge clk);
    req_i = 2'b11;
    #1;
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw_o}, 32'd1);
    req_i = 2'b00;
    rst = 1'b0;

    // Both ports read continuously: grants alternate starting with the core.
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b00, 2'b10, 32'h0, 32'h0, 2'b10, 32'h4, 32'h0, 1'b0);
    idle();

    // Core word write then read back.
    step(2'b01, 2'b01, 2'b10, 32'h0, 32'hAAAAAAAA, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b01, 2'b00, 2'b10, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    idle();
    chk("t1_rdata", obs_rdata, 32'hAAAAAAAA);

    // Debug lock over three writes while the core keeps requesting.
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 2'b11, 2'b10, 32'h10, 32'h11111111, 2'b10, 32'h20 + 32'(4 * i), 32'h22220000 + 32'(i), 1'b1);
      chk("lock_core_blocked", {31'd0, obs_gnt[0]}, 32'd0);
    end
    step(2'b01, 2'b01, 2'b10, 32'h10, 32'h11111111, 2'b10, 32'h0, 32'h0, 1'b0);
    chk("lock_release_gnt", {30'd0, obs_gnt}, 32'd1);
    idle();

    // Error accesses: misaligned half, misaligned word, out of range, size 11, bad store.
    step(2'b01, 2'b00, 2'b01, 32'h5, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b01, 2'b00, 2'b10, 32'h6, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b01, 2'b00, 2'b00, 32'h800, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b01, 2'b00, 2'b11, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b01, 2'b01, 2'b10, 32'h2, 32'hDEADBEEF, 2'b10, 32'h0, 32'h0, 1'b0);
    idle();

    // Word write, debug byte write into lane 1, word read-back.
    step(2'b01, 2'b01, 2'b10, 32'h8, 32'hCCCCCCCC, 2'b10, 32'h0, 32'h0, 1'b0);
    step(2'b10, 2'b10, 2'b10, 32'h0, 32'h0, 2'b00, 32'h9, 32'h000000BB, 1'b0);
    step(2'b01, 2'b00, 2'b10, 32'h8, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    idle();
    chk("t5_rdata", obs_rdata, 32'hCCCCBBCC);

    // Reset mid-cycle with a read outstanding.
    step(2'b01, 2'b00, 2'b10, 32'h8, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req_i = 2'b11;
    we_i = 2'b00;
    #1;
    chk("midrst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("midrst_rvalid", {30'd0, rvalid_o}, 32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    chk("midrst_mem_rw", {31'd0, mem_rw_o}, 32'd1);
    pend_v = 1'b0;
    last_m = 1;
    @(negedge clk);
    rst = 1'b0;
    req_i = 2'b00;
    step(2'b11, 2'b00, 2'b10, 32'h0, 32'h0, 2'b10, 32'h4, 32'h0, 1'b0);
    chk("postrst_tie", {30'd0, obs_gnt}, 32'd1);
    idle();

    // Randomized traffic against the reference model.
    act[0] = 1'b0;
    act[1] = 1'b0;
    r_lock = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 99) < 60) begin
          act[p]   = 1'b1;
          r_we[p]  = 1'($urandom_range(0, 1));
          r_sec[p] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          r_addr[p] = 32'($urandom_range(0, 2047));
          if (r_sec[p] == 2'b01) r_addr[p][0] = 1'b0;
          if (r_sec[p] == 2'b10) r_addr[p][1:0] = 2'b00;
          if ($urandom_range(0, 9) == 0) r_addr[p] = r_addr[p] + 32'd1;
          if ($urandom_range(0, 19) == 0) r_addr[p] = 32'h800 + 32'($urandom_range(0, 4095));
          r_wd[p] = $urandom;
        end
      end
      r_lock = r_lock ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      step({act[1], act[0]}, {r_we[1], r_we[0]},
           r_sec[0], r_addr[0], r_wd[0], r_sec[1], r_addr[1], r_wd[1], r_lock);
      for (int p = 0; p < 2; p++)
        if (obs_gnt[p]) act[p] = 1'b0;
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
